// File: rtl/mem_stage_ws_if.sv
// Bus between the EX/MEM pipeline register, the memory stage and the writeback stage.
// The master modport is the pipeline side: it drives the *_m slot and receives the stall and MEM/WB contents.
interface mem_stage_ws_if;
    logic        in_valid;
    logic [31:0] pc_m;
    logic [31:0] result_m;
    logic [31:0] store_data_m;
    logic        fwd_sel;
    logic [31:0] fwd_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [4:0]  wa_m;
    logic        reg_write_m;

    logic        stall;
    logic [31:0] pc_w;
    logic [31:0] result_w;
    logic [31:0] load_data_w;
    logic [4:0]  wa_w;
    logic        reg_write_w;
    logic        valid_w;
    logic        addr_err_w;

    modport master (
        output in_valid, pc_m, result_m, store_data_m, fwd_sel, fwd_data,
               mem_read, mem_write, mem_size, mem_unsigned, wa_m, reg_write_m,
        input  stall, pc_w, result_w, load_data_w, wa_w, reg_write_w, valid_w, addr_err_w
    );

    modport slave (
        input  in_valid, pc_m, result_m, store_data_m, fwd_sel, fwd_data,
               mem_read, mem_write, mem_size, mem_unsigned, wa_m, reg_write_m,
        output stall, pc_w, result_w, load_data_w, wa_w, reg_write_w, valid_w, addr_err_w
    );
endinterface

// File: rtl/mem_stage_ws.sv
// MIPS memory stage: byte-addressable data memory with configurable wait states,
// sub-word loads/stores, alignment checking, and a MEM/WB register that bubbles while stalled.
module mem_stage_ws #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_stage_ws_if.slave io_bus
);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam bit         ONE_WAIT  = (WAIT_CYCLES == 1);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_store_data;
    logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

    logic [31:0]       w_addr;
    logic [ADDR_W-1:0] w_index;
    logic              w_is_mem;
    logic              w_is_write;
    logic              w_is_load;
    logic              w_aligned;
    logic              w_addr_err;
    logic              w_accept;
    logic              w_commit;
    logic              w_stall;
    logic [31:0]       w_sel_data;
    logic [31:0]       w_wdata_src;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic [31:0]       w_rword;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;

    assign w_addr     = io_bus.result_m;
    assign w_index    = w_addr[ADDR_W+1:2];
    assign w_is_mem   = io_bus.in_valid && (io_bus.mem_read || io_bus.mem_write);
    assign w_is_write = io_bus.mem_write;
    assign w_is_load  = io_bus.mem_read && !io_bus.mem_write;

    always_comb begin
        w_aligned = 1'b1;
        case (io_bus.mem_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = (w_addr[0] == 1'b0);
            default: w_aligned = (w_addr[1:0] == 2'b00);
        endcase
    end

    // Reset gates accept/commit/stall so an asserted reset kills the handshake immediately.
    assign w_addr_err = w_is_mem && !w_aligned;
    assign w_accept   = rst_n && (r_state == S_IDLE) && w_is_mem && w_aligned;
    assign w_commit   = rst_n && ((r_state == S_COMMIT) || (w_accept && !HAS_WAIT));
    assign w_stall    = rst_n && ((w_accept && HAS_WAIT) || (r_state == S_WAIT));
    assign io_bus.stall = w_stall;

    assign w_sel_data  = io_bus.fwd_sel ? io_bus.fwd_data : io_bus.store_data_m;
    assign w_wdata_src = (r_state == S_COMMIT) ? r_store_data : w_sel_data;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_wdata_src;
        case (io_bus.mem_size)
            2'b00: begin
                w_be[w_addr[1:0]] = 1'b1;
                w_wdata           = {4{w_wdata_src[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_wdata_src[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_index];
    assign w_half  = w_addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_byte = w_rword[7:0];
        case (w_addr[1:0])
            2'b00:   w_byte = w_rword[7:0];
            2'b01:   w_byte = w_rword[15:8];
            2'b10:   w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    always_comb begin
        w_load_data = w_rword;
        case (io_bus.mem_size)
            2'b00:   w_load_data = io_bus.mem_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = io_bus.mem_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = w_rword;
        endcase
    end

    // Sequencer and MEM/WB register; the counter holds the number of WAIT cycles still to run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_cnt              <= 4'd0;
            r_store_data       <= 32'd0;
            io_bus.pc_w        <= 32'd0;
            io_bus.result_w    <= 32'd0;
            io_bus.load_data_w <= 32'd0;
            io_bus.wa_w        <= 5'd0;
            io_bus.reg_write_w <= 1'b0;
            io_bus.valid_w     <= 1'b0;
            io_bus.addr_err_w  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && HAS_WAIT) begin
                        r_store_data <= w_sel_data;
                        r_cnt        <= WAIT_INIT;
                        r_state      <= ONE_WAIT ? S_COMMIT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) r_state <= S_COMMIT;
                end
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase

            if (w_stall || !io_bus.in_valid) begin
                io_bus.pc_w        <= 32'd0;
                io_bus.result_w    <= 32'd0;
                io_bus.load_data_w <= 32'd0;
                io_bus.wa_w        <= 5'd0;
                io_bus.reg_write_w <= 1'b0;
                io_bus.valid_w     <= 1'b0;
                io_bus.addr_err_w  <= 1'b0;
            end else begin
                io_bus.pc_w        <= io_bus.pc_m;
                io_bus.result_w    <= io_bus.result_m;
                io_bus.load_data_w <= (w_commit && w_is_load) ? w_load_data : 32'd0;
                io_bus.wa_w        <= io_bus.wa_m;
                io_bus.reg_write_w <= io_bus.reg_write_m && !w_addr_err;
                io_bus.valid_w     <= 1'b1;
                io_bus.addr_err_w  <= w_addr_err;
            end
        end
    end
endmodule
